// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx
// Final output stage of the audio path. Once per frame it captures the PCM
// and PSG sample pairs and mixes each side with saturating addition. It
// then shifts the mixed frame out to an external I2S DAC. The next_sample
// strobe paces the upstream sources. Frame rate is clk / (128 * BCK_HALF).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   pcm_left     signed 16-bit PCM sample, left
//   pcm_right    signed 16-bit PCM sample, right
//   psg_left     signed 16-bit PSG sample, left
//   psg_right    signed 16-bit PSG sample, right
//   mute         when high in the capture cycle the frame carries zeros
//   next_sample  one-clk pulse per frame, aligned with the capture
//   i2s_bck      I2S bit clock
//   i2s_lrck     I2S word select (0 = left, 1 = right)
//   i2s_data     I2S serial data, MSB first, one BCK after the LRCK edge
module audio_i2s_tx #(
    parameter int BCK_HALF = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic        mute,
    output logic        next_sample,
    output logic        i2s_bck,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    // A one-cycle divider still needs a 1-bit counter to stay legal.
    localparam int              DIV_W    = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);

    // Saturating add of two signed 16-bit values. The sum is formed in
    // 17 bits, so it can never wrap there. The 16-bit result overflows
    // exactly when the top two bits of the sum disagree.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        logic [15:0] res;
        sum = {a[15], a} + {b[15], b};
        if (sum[16] != sum[15]) begin
            res = sum[16] ? 16'h8000 : 16'h7FFF;
        end else begin
            res = sum[15:0];
        end
        return res;
    endfunction

    logic [DIV_W-1:0] div_cnt_r;
    logic             bck_r;
    logic [5:0]       bit_cnt_r;
    logic             lrck_r;
    logic             data_r;
    logic             next_sample_r;
    logic [63:0]      frame_r;

    logic             tick_s;
    logic             fall_s;
    logic             capture_s;
    logic [5:0]       bit_cnt_nxt_s;
    logic [15:0]      mix_left_s;
    logic [15:0]      mix_right_s;

    // Decode divider tick, BCK falling event, capture event and the mixed words.
    always_comb begin
        tick_s        = (div_cnt_r == DIV_LAST);
        fall_s        = tick_s & bck_r;
        bit_cnt_nxt_s = bit_cnt_r + 6'd1;
        if (fall_s && (bit_cnt_nxt_s == 6'd0)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (mute) begin
            mix_left_s  = 16'h0000;
            mix_right_s = 16'h0000;
        end else begin
            mix_left_s  = sat16(pcm_left, psg_left);
            mix_right_s = sat16(pcm_right, psg_right);
        end
    end

    // Bit-clock divider: toggles BCK every BCK_HALF clk cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= '0;
            bck_r     <= 1'b0;
        end else if (tick_s) begin
            div_cnt_r <= '0;
            bck_r     <= ~bck_r;
        end else begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
            bck_r     <= bck_r;
        end
    end

    // Frame sequencing on BCK falling events. The frame is captured and
    // loaded when entering slot 0, and shifted MSB first on every other slot.
    // Slot 0 outputs 0, which gives the one-BCK I2S delay after LRCK changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r     <= 6'd63;
            lrck_r        <= 1'b1;
            data_r        <= 1'b0;
            next_sample_r <= 1'b0;
            frame_r       <= 64'h0;
        end else begin
            next_sample_r <= capture_s;
            if (fall_s) begin
                bit_cnt_r <= bit_cnt_nxt_s;
                lrck_r    <= bit_cnt_nxt_s[5];
                if (capture_s) begin
                    frame_r <= {mix_left_s, 16'h0000, mix_right_s, 16'h0000};
                    data_r  <= 1'b0;
                end else begin
                    frame_r <= {frame_r[62:0], 1'b0};
                    data_r  <= frame_r[63];
                end
            end else begin
                bit_cnt_r <= bit_cnt_r;
                lrck_r    <= lrck_r;
                frame_r   <= frame_r;
                data_r    <= data_r;
            end
        end
    end

    assign next_sample = next_sample_r;
    assign i2s_bck     = bck_r;
    assign i2s_lrck    = lrck_r;
    assign i2s_data    = data_r;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Testbench for audio_i2s_tx.
// Runs two instances side by side, one with BCK_HALF=4 and one with BCK_HALF=1.
// Each instance has its own inputs and reset.
//
// Reference model, written from the externally visible rules:
//   - cycle-count formulas give the expected bck, lrck and next_sample.
//   - at every capture cycle, integer arithmetic plus clamping builds the
//     expected 64-bit frame, which is pushed into a queue.
//
// Checking:
//   - a monitor deserialises i2s_data on BCK falling events, aligned to the
//     LRCK 1->0 edge.
//   - at the end of each frame it pops the queue and compares.
//
// Inputs are re-randomised every cycle, so data that changes mid-frame is
// always present. Captures use a directed table first, then random values.
module tb_audio_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check(input string name, input int inst, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s inst%0d t=%0t: got %h expected %h", name, inst, $time, got, want);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int H  = (g == 0) ? 4 : 1;
        localparam int FR = 128 * H;

        logic        rst_n = 1'b0;
        logic [15:0] pl = 16'h0, pr = 16'h0, sl = 16'h0, sr = 16'h0;
        logic        mute = 1'b0;
        logic        ns, bck, lrck, data;

        int          cyc = 0;
        logic [63:0] exp_q[$];
        logic        pbck = 1'b0;
        logic        plrck = 1'b1;
        int          mb = 0;
        bit          mact = 1'b0;
        logic [63:0] bits = 64'h0;
        int          ncmp = 0;

        audio_i2s_tx #(.BCK_HALF(H)) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .pcm_left   (pl),
            .pcm_right  (pr),
            .psg_left   (sl),
            .psg_right  (sr),
            .mute       (mute),
            .next_sample(ns),
            .i2s_bck    (bck),
            .i2s_lrck   (lrck),
            .i2s_data   (data)
        );

        // True when clk edge number c (counted from 1 after release) is a capture.
        function automatic bit is_cap(input int c);
            return (c >= 2 * H) && (((c - 2 * H) % FR) == 0);
        endfunction

        // Frame slot after clk edge c.
        function automatic int bidx(input int c);
            return (c < 2 * H) ? 63 : (((c / (2 * H)) - 1) % 64);
        endfunction

        function automatic int clamp(input int v);
            if (v > 32767)  return 32767;
            if (v < -32768) return -32768;
            return v;
        endfunction

        function automatic logic [63:0] ref_frame(input logic [15:0] a_l, input logic [15:0] b_l,
                                                  input logic [15:0] a_r, input logic [15:0] b_r,
                                                  input logic m);
            int l, r;
            l = clamp(int'($signed(a_l)) + int'($signed(b_l)));
            r = clamp(int'($signed(a_r)) + int'($signed(b_r)));
            if (m) begin
                l = 0;
                r = 0;
            end
            return {16'(l), 16'h0000, 16'(r), 16'h0000};
        endfunction

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) cyc <= 0;
            else        cyc <= cyc + 1;
        end

        always @(posedge clk) begin
            if (rst_n === 1'b1 && is_cap(cyc + 1))
                exp_q.push_back(ref_frame(pl, sl, pr, sr, mute));
        end

        task automatic check_cycle();
            if (!rst_n) begin
                check("rst_bck",  g, 64'(bck),  64'(0));
                check("rst_lrck", g, 64'(lrck), 64'(1));
                check("rst_data", g, 64'(data), 64'(0));
                check("rst_ns",   g, 64'(ns),   64'(0));
            end else begin
                check("bck",         g, 64'(bck),  64'((cyc / H) % 2));
                check("next_sample", g, 64'(ns),   64'(is_cap(cyc)));
                check("lrck",        g, 64'(lrck), 64'(bidx(cyc) >= 32));
                if (cyc < 2 * H) check("pre_data", g, 64'(data), 64'(0));
            end
        endtask

        task automatic monitor_step();
            logic [63:0] e;
            if (!rst_n) begin
                pbck  = 1'b0;
                plrck = 1'b1;
                mact  = 1'b0;
                mb    = 0;
            end else begin
                if (pbck && !bck) begin
                    if (plrck && !lrck) begin
                        mb   = 0;
                        mact = 1'b1;
                    end
                    if (mact) begin
                        bits[63 - mb] = data;
                        if (mb == 63) begin
                            if (exp_q.size() == 0) begin
                                check("frame_pending", g, 64'(exp_q.size()), 64'(1));
                            end else begin
                                e = exp_q.pop_front();
                                check("frame", g, bits, {1'b0, e[63:1]});
                                ncmp++;
                            end
                            mact = 1'b0;
                        end
                        mb++;
                    end
                end
                pbck  = bck;
                plrck = lrck;
            end
        endtask

        task automatic drive();
            int c, k;
            c = cyc + 1;
            if (rst_n && is_cap(c)) begin
                k = (c - 2 * H) / FR;
                case (k)
                    0: begin pl = 16'h8001; sl = 16'h0000; pr = 16'h7FFE; sr = 16'h0000; mute = 1'b0; end
                    1: begin pl = 16'h7000; sl = 16'h2000; pr = 16'h9000; sr = 16'hA000; mute = 1'b0; end
                    2: begin pl = 16'h0100; sl = 16'hFF80; pr = 16'h0001; sr = 16'hFFFF; mute = 1'b0; end
                    3: begin pl = 16'h1234; sl = 16'h0567; pr = 16'hABCD; sr = 16'h0100; mute = 1'b1; end
                    default: begin
                        pl = 16'($urandom); sl = 16'($urandom);
                        pr = 16'($urandom); sr = 16'($urandom);
                        mute = ($urandom_range(0, 7) == 0);
                    end
                endcase
            end else begin
                pl = 16'($urandom); sl = 16'($urandom);
                pr = 16'($urandom); sr = 16'($urandom);
                mute = 1'($urandom_range(0, 1));
            end
        endtask

        initial begin
            rst_n = 1'b0;
            drive();
            repeat (4) begin
                @(negedge clk);
                check_cycle();
                monitor_step();
                drive();
            end
            rst_n = 1'b1;
            // Run six full frames, then break in at slot 20 of the seventh.
            for (int i = 0; i < 10 * FR; i++) begin
                @(negedge clk);
                check_cycle();
                monitor_step();
                if (ncmp >= 6 && cyc >= 2 * H && bidx(cyc) == 20) break;
                drive();
            end
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            check_cycle();
            monitor_step();
            repeat (3) begin
                @(negedge clk);
                check_cycle();
                monitor_step();
                drive();
            end
            rst_n = 1'b1;
            // Restart: four more frames, stopping before the fifth capture.
            for (int i = 0; i < 4 * FR + H; i++) begin
                @(negedge clk);
                check_cycle();
                monitor_step();
                drive();
            end
            check("frames_compared", g, 64'(ncmp), 64'(10));
            check("queue_drained",   g, 64'(exp_q.size()), 64'(0));
            n_done++;
        end
    end

    initial begin
        for (int i = 0; i < 20000 && n_done < 2; i++) @(posedge clk);
        if (n_done < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: instances finished %0d expected 2", n_done);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Downstream output stage of the audio path. Mixes the signed 16-bit PCM channel pair with a second signed 16-bit source (PSG) using saturating addition, and serialises the result to an external I2S DAC. Generates the `next_sample` frame strobe that paces the upstream PCM and PSG blocks. Frame rate is clk / (128·BCK_HALF), so 25 MHz with BCK_HALF=4 gives 48828 Hz.

## Interface
- `BCK_HALF`, default 4: clk cycles per BCK half-period; legal values are ≥1.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `pcm_left`, `pcm_right`  in  16: signed PCM samples.
- `psg_left`, `psg_right`  in  16: signed PSG samples.
- `mute`  in  1: when set at a capture, the frame carries zeros.
- `next_sample`  out  1: one-clk pulse per frame, asserted in the capture cycle.
- `i2s_bck`  out  1: bit clock.
- `i2s_lrck`  out  1: word select; 0 = left, 1 = right.
- `i2s_data`  out  1: serial data, MSB first.

## Operation
- **Divider**
  - `div_cnt` counts 0..BCK_HALF-1.
  - On each clk with `div_cnt`==BCK_HALF-1: `div_cnt` returns to 0 and `i2s_bck` toggles.
  - A toggle 1→0 is a *falling event*. All other register updates happen only on falling events.
- **Frame counter**
  - `bit_cnt[5:0]` increments by 1 per falling event and wraps from 63 to 0.
  - `i2s_lrck` = new `bit_cnt[5]`.
- **Capture** (falling event entering `bit_cnt`=0):
  - Sample all four inputs in that same clk cycle.
  - `next_sample` pulses for exactly this one clk.
  - Mix each side: `mix` = sat16(sext17(pcm) + sext17(psg)).
    - Result >32767 → 16'h7FFF.
    - Result <−32768 → 16'h8000.
    - Otherwise the low 16 bits.
  - If `mute`=1, both mixes are 0.
  - Load the frame register with {mixL, 16'h0000, mixR, 16'h0000} (64 bits).
- **Data output** (on a falling event entering `bit_cnt`=b):
  - b=0: `i2s_data`=0.
  - b≥1: `i2s_data` = frame bit at position b−1, counting from the MSB (position 0).
  - This places left MSB at b=1 and right MSB at b=33, i.e. standard I2S one-BCK delay after the LRCK edge.
- **Input stability**: inputs are ignored outside the capture cycle. Input changes mid-frame never affect the frame in flight.
- **Latency**: upstream outputs updated in response to `next_sample` appear in the following frame (one-frame latency by construction).

## Timing
- **Reset values**:
  - Outputs: `i2s_bck`=0, `i2s_lrck`=1, `i2s_data`=0, `next_sample`=0.
  - Internal: `div_cnt`=0, `bit_cnt`=63, frame register=0.
- **After `rst_n` deassert**:
  - First rising BCK at clk cycle BCK_HALF.
  - First falling event at cycle 2·BCK_HALF. That event is a capture: `bit_cnt`=0, `i2s_lrck`=0, and the first `next_sample` pulse.
- **Period**: `next_sample` recurs exactly every 128·BCK_HALF clk cycles.
- **Registered outputs**: `i2s_lrck` and `i2s_data` are registered and change only on the same clk edge where `i2s_bck` goes 0. They are stable for the whole high phase.
- **BCK_HALF=1**: `i2s_bck` = clk/2, and every second clk is a falling event. The behaviour is otherwise identical.
- **Reset mid-frame**: all state returns immediately to reset values (asynchronous). The partial frame is discarded and no `next_sample` is emitted until the first falling event after release.
- **No combinational paths** from inputs to outputs.

## Test plan
1. **Reset and first capture.** Hold `rst_n`=0, then release (BCK_HALF=4).
   - All outputs hold their reset values.
   - First `i2s_bck` rise at cycle 4.
   - First `next_sample` pulse at cycle 8, with `i2s_lrck`→0.
   - `next_sample` then repeats every 512 cycles.
2. **Serialisation.** pcm_left=16'h8001, pcm_right=16'h7FFE, psg=0.
   - Left slot, bits b=1..16: 1,0…0,1; b=17..32: 0.
   - Right slot, bits b=33..48: 0,1…1,0; b=49..63 and b=0: 0.
3. **Saturation.**
   - pcm_left=16'h7000 + psg_left=16'h2000 → left word 16'h7FFF.
   - pcm_right=16'h9000 + psg_right=16'hA000 → right word 16'h8000.
   - pcm_left=16'h0100 + psg_left=16'hFF80 → 16'h0080.
4. **Input stability.** Change every input 10 cycles after `next_sample` → the current frame still shifts the captured values; the new values appear only in the next frame.
5. **Mute.** `mute`=1 at the capture with nonzero inputs → all 64 data bits are 0. `mute`=1 only between captures → no effect.
6. **Reset mid-frame and BCK_HALF=1.**
   - Assert `rst_n`=0 at `bit_cnt`=20 → outputs return to reset values within the same cycle, and the restart timing matches scenario 1.
   - With BCK_HALF=1 → `next_sample` period is 128 cycles and the bit pattern is unchanged from scenario 2.
